// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronizes device request lines, latches
// pending bits, applies a mask and answers CPU data-side reads with registered data.
module irq_controller #(
    parameter logic [17:0] BASE_ADDR = 18'h3FFF0,
    parameter int          N_IRQ     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [15:0] irq_in,
    input  logic [3:0]  mem_we,
    input  logic [17:0] mem_write_addr,
    input  logic [31:0] mem_write_data,
    input  logic [17:0] mem_read1_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [15:0] interrupts
);

    localparam logic [15:0] IMPL = 16'((32'd1 << N_IRQ) - 32'd1);

    logic [15:0] sync1, sync2, prev;
    logic [15:0] pending, mask, mode;
    logic [15:0] set_evt, force_set, clr, lane_mask, wr_val;
    logic [17:0] wr_off, rd_off;
    logic        sel_pend, sel_mask, sel_mode, sel_force;
    logic [15:0] masked;
    logic        st_valid;
    logic [3:0]  st_idx;
    logic [31:0] rd_next;
    logic        unused_bits;

    // Upper byte lanes and data bits carry nothing for a 16-bit register file.
    assign unused_bits = ^{mem_write_data[31:16], mem_we[3:2]};

    assign wr_off    = mem_write_addr - BASE_ADDR;
    assign rd_off    = mem_read1_addr - BASE_ADDR;
    assign lane_mask = {{8{mem_we[1]}}, {8{mem_we[0]}}};
    assign wr_val    = mem_write_data[15:0] & lane_mask & IMPL;

    assign sel_pend  = clk_en && (wr_off == 18'd0);
    assign sel_mask  = clk_en && (wr_off == 18'd1);
    assign sel_mode  = clk_en && (wr_off == 18'd2);
    assign sel_force = clk_en && (wr_off == 18'd3);

    assign clr       = sel_pend  ? wr_val : 16'h0000;
    assign force_set = sel_force ? wr_val : 16'h0000;
    assign set_evt   = (mode & sync2 & ~prev) | (~mode & sync2);

    assign masked     = pending & mask;
    assign interrupts = masked;

    always_comb begin
        st_valid = |masked;
        st_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (masked[i]) st_idx = 4'(i);
        end
    end

    always_comb begin
        rd_next = 32'h0;
        case (rd_off)
            18'd0:   rd_next = {16'h0000, pending};
            18'd1:   rd_next = {16'h0000, mask};
            18'd2:   rd_next = {16'h0000, mode};
            18'd4:   rd_next = {st_valid, 27'h0, st_idx};
            default: rd_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 16'h0000;
            sync2 <= 16'h0000;
            prev  <= 16'h0000;
        end else begin
            sync1 <= irq_in & IMPL;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Set terms are ORed after the clear so a same-cycle request always survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 16'h0000;
            mask    <= 16'h0000;
            mode    <= 16'h0000;
        end else begin
            pending <= (set_evt | force_set | (pending & ~clr)) & IMPL;
            if (sel_mask) mask <= ((mask & ~lane_mask) | wr_val) & IMPL;
            if (sel_mode) mode <= ((mode & ~lane_mask) | wr_val) & IMPL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'h0;
            rd_hit  <= 1'b0;
        end else if (clk_en) begin
            rd_data <= rd_next;
            rd_hit  <= (rd_off < 18'd5);
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a behavioural model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_irq_controller;

    localparam logic [17:0] BASE = 18'h3FFF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic [15:0] irq_in = 16'h0;
    logic [3:0]  mem_we = 4'h0;
    logic [17:0] mem_write_addr = 18'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [17:0] mem_read1_addr = 18'h0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [15:0] interrupts;

    int errors = 0;
    int checks = 0;

    irq_controller #(.BASE_ADDR(BASE), .N_IRQ(16)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .irq_in(irq_in),
        .mem_we(mem_we), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read1_addr(mem_read1_addr),
        .rd_data(rd_data), .rd_hit(rd_hit), .interrupts(interrupts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw line samples taken at the last three edges; a request is recognised
    // from the sample two edges old (and, for edge sources, the one before it).
    logic [15:0] m_pend, m_mask, m_mode, m_rd_hit_v;
    logic [15:0] samp_1ago, samp_2ago, samp_3ago;
    logic [31:0] m_rd;
    logic        m_hit;

    function automatic logic [31:0] m_status(input logic [15:0] v);
        for (int i = 0; i < 16; i++)
            if (v[i]) return {1'b1, 27'h0, 4'(i)};
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_mask = 0; m_mode = 0;
            samp_1ago = 0; samp_2ago = 0; samp_3ago = 0;
            m_rd = 0; m_hit = 0;
        end else begin
            logic [15:0] req, wval, setf, clrf;
            int woff, roff;
            req  = (~m_mode & samp_2ago) | (m_mode & samp_2ago & ~samp_3ago);
            wval = mem_write_data[15:0] & {{8{mem_we[1]}}, {8{mem_we[0]}}};
            woff = int'(mem_write_addr) - int'(BASE);
            roff = int'(mem_read1_addr) - int'(BASE);
            setf = 0; clrf = 0;
            if (clk_en) begin
                m_hit = (roff >= 0 && roff <= 4);
                case (roff)
                    0: m_rd = {16'h0, m_pend};
                    1: m_rd = {16'h0, m_mask};
                    2: m_rd = {16'h0, m_mode};
                    4: m_rd = m_status(m_pend & m_mask);
                    default: m_rd = 0;
                endcase
                for (int b = 0; b < 16; b++) begin
                    if (mem_we[b/8]) begin
                        if (woff == 0) clrf[b] = wval[b];
                        if (woff == 3) setf[b] = wval[b];
                        if (woff == 1) m_mask[b] = wval[b];
                        if (woff == 2) m_mode[b] = wval[b];
                    end
                end
            end
            m_pend = req | setf | (m_pend & ~clrf);
            samp_3ago = samp_2ago; samp_2ago = samp_1ago; samp_1ago = irq_in;
        end
    end

    always @(negedge clk) begin
        chk("model_interrupts", {16'h0, interrupts}, {16'h0, m_pend & m_mask});
        chk("model_rd_data", rd_data, m_rd);
        chk("model_rd_hit", {31'h0, rd_hit}, {31'h0, m_hit});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int off, input logic [31:0] data, input logic [3:0] we);
        mem_write_addr = BASE + 18'(off);
        mem_write_data = data;
        mem_we = we;
        @(negedge clk);
        mem_we = 4'h0;
    endtask

    task automatic rd(input int off);
        mem_read1_addr = BASE + 18'(off);
        @(negedge clk);
        mem_read1_addr = 18'h0;
    endtask

    initial begin
        cyc(2);
        chk("reset_interrupts", {16'h0, interrupts}, 32'h0);
        chk("reset_rd_hit", {31'h0, rd_hit}, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Edge source on bit 0
        wr(2, 32'h1, 4'b0011);
        wr(1, 32'h1, 4'b0011);
        irq_in = 16'h0001;
        @(negedge clk);
        irq_in = 16'h0000;
        chk("edge_k", {16'h0, interrupts}, 32'h0);
        @(negedge clk);
        chk("edge_k1", {16'h0, interrupts}, 32'h0);
        @(negedge clk);
        chk("edge_k2", {16'h0, interrupts}, 32'h0001);
        irq_in = 16'h0001;
        cyc(4);
        wr(0, 32'h1, 4'b0011);
        chk("edge_w1c", {16'h0, interrupts}, 32'h0);
        cyc(3);
        chk("edge_no_retrigger", {16'h0, interrupts}, 32'h0);
        irq_in = 16'h0000;

        // Level source on bit 5
        wr(2, 32'h0, 4'b0011);
        wr(1, 32'h20, 4'b0011);
        irq_in = 16'h0020;
        cyc(3);
        chk("level_set", {16'h0, interrupts}, 32'h0020);
        wr(0, 32'h20, 4'b0011);
        chk("level_sticky", {16'h0, interrupts}, 32'h0020);
        irq_in = 16'h0000;
        cyc(3);
        wr(0, 32'h20, 4'b0011);
        chk("level_cleared", {16'h0, interrupts}, 32'h0);

        // Priority / STATUS
        wr(3, 32'h8140, 4'b0011);
        wr(1, 32'hFF00, 4'b0011);
        chk("prio_interrupts", {16'h0, interrupts}, 32'h8100);
        rd(4);
        chk("status_hit", {31'h0, rd_hit}, 32'h1);
        chk("status_data", rd_data, 32'h80000008);
        rd(3);
        chk("force_reads_zero", rd_data, 32'h0);
        wr(0, 32'hFFFF, 4'b0011);

        // Byte lanes and clk_en
        wr(1, 32'h0, 4'b0011);
        wr(1, 32'hFFFF, 4'b0010);
        rd(1);
        chk("lane_mask", rd_data, 32'h0000FF00);
        clk_en = 1'b0;
        wr(1, 32'hFFFF, 4'b0011);
        mem_read1_addr = BASE + 18'd5;
        @(negedge clk);
        chk("clken_hold_hit", {31'h0, rd_hit}, 32'h1);
        chk("clken_hold_data", rd_data, 32'h0000FF00);
        clk_en = 1'b1;
        rd(1);
        chk("clken_no_write", rd_data, 32'h0000FF00);
        rd(5);
        chk("undecoded_hit", {31'h0, rd_hit}, 32'h0);
        chk("undecoded_data", rd_data, 32'h0);
        wr(3, 32'hFFFF0000, 4'b1100);
        chk("upper_lanes_ignored", {16'h0, interrupts}, 32'h0);

        // Collision: edge on bit 3 lands with a W1C of bit 3
        wr(2, 32'h8, 4'b0011);
        wr(1, 32'h8, 4'b0011);
        irq_in = 16'h0008;
        cyc(2);
        wr(0, 32'h8, 4'b0011);
        chk("collision_set_wins", {16'h0, interrupts}, 32'h0008);
        wr(0, 32'h8, 4'b0011);
        chk("collision_later_clear", {16'h0, interrupts}, 32'h0);
        irq_in = 16'h0000;

        // Asynchronous reset mid-operation
        wr(3, 32'hFFFF, 4'b0011);
        wr(1, 32'hFFFF, 4'b0011);
        chk("pre_reset_all", {16'h0, interrupts}, 32'hFFFF);
        rd(4);
        chk("pre_reset_status", rd_data, 32'h80000000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_interrupts", {16'h0, interrupts}, 32'h0);
        chk("async_rst_rd_hit", {31'h0, rd_hit}, 32'h0);
        chk("async_rst_rd_data", rd_data, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        rd(4);
        chk("post_reset_status", rd_data, 32'h0);
        chk("post_reset_hit", {31'h0, rd_hit}, 32'h1);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
